// File: rtl/wiscsc15_mem_arb.sv
// wiscsc15_mem_arb
//   Shares one fixed-latency, single-port unified memory between the fetch
//   port (if_*) and the data port (dm_*: lw/sw/call/ret). Each access runs
//   grant -> issue -> wait -> respond. The core's fetch and data stall logic
//   is driven by the grant and valid pulses.
//
// Parameters
//   AW       address width
//   DW       data width
//   MEM_LAT  cycles from mem_en_o to the last memory cycle (>= 1)
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   if_req_i / if_addr_i       fetch request; held until if_grant_o
//   if_grant_o, if_valid_o     1-cycle pulses: accepted / if_rdata_o valid
//   if_rdata_o                 fetched word, held until the next if_valid_o
//   dm_req_i, dm_we_i,
//   dm_addr_i, dm_wdata_i      data request; held until dm_grant_o
//   dm_grant_o, dm_valid_o     1-cycle pulses: accepted / load data or store ack
//   dm_rdata_o                 load data, held until the next dm_valid_o
//   mem_en_o, mem_we_o         memory strobe (1 cycle per access), write enable
//   mem_addr_o, mem_wdata_o    latched access address and store data
//   mem_rdata_i                memory read data
//   busy_o                     1 in every state except IDLE
//
// Build option
//   WISCSC15_ARB_FAIR_EN : after two consecutive DM wins taken while a fetch
//   was waiting, the next contended pick goes to IF. Without it DM always
//   has priority and fetch can starve under continuous dm_req.

module wiscsc15_mem_arb #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_grant_o,
  output logic          if_valid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_grant_o,
  output logic          dm_valid_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          turn_q, turn_d;
  logic          owner_q;            // 1 = DM owns the access in flight
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;

  logic          win, pick_dm, if_pri, cap;

  // IDLE spends one turnaround cycle after each DONE before sampling again,
  // which sets the back-to-back cadence to MEM_LAT+3 cycles.
`ifdef WISCSC15_ARB_FAIR_EN
  logic [1:0] streak_q, streak_d;
  assign if_pri = (streak_q == 2'd2);
`else
  assign if_pri = 1'b0;
`endif

  assign pick_dm = dm_req_i && !(if_req_i && if_pri);
  assign win     = (state_q == IDLE) && !turn_q && (dm_req_i || if_req_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    turn_d  = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE:  if (win) state_d = ISSUE;
      ISSUE: begin
        cnt_d = CW'(MEM_LAT - 1);
        if (MEM_LAT == 1) begin
          cap     = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // cnt_q == 1 marks the last memory cycle (T+MEM_LAT)
        if (cnt_q == CW'(1)) begin
          cap     = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        turn_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WISCSC15_ARB_FAIR_EN
  always_comb begin
    streak_d = streak_q;
    if (win) begin
      // Only DM wins taken while a fetch was waiting count toward the streak.
      if (pick_dm && if_req_i) streak_d = streak_q + 2'd1;
      else                     streak_d = 2'd0;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      turn_q     <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef WISCSC15_ARB_FAIR_EN
      streak_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
`ifdef WISCSC15_ARB_FAIR_EN
      streak_q <= streak_d;
`endif
      if (win) begin
        owner_q <= pick_dm;
        we_q    <= pick_dm && dm_we_i;
        addr_q  <= pick_dm ? dm_addr_i : if_addr_i;
        if (pick_dm) wdata_q <= dm_wdata_i;
      end
      // Stores leave dm_rdata untouched; their DONE pulse is only an ack.
      if (cap && !owner_q)          if_rdata_q <= mem_rdata_i;
      if (cap && owner_q && !we_q)  dm_rdata_q <= mem_rdata_i;
    end
  end

  assign mem_en_o    = (state_q == ISSUE);
  assign mem_we_o    = mem_en_o && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_grant_o  = mem_en_o && !owner_q;
  assign dm_grant_o  = mem_en_o && owner_q;
  assign if_valid_o  = (state_q == DONE) && !owner_q;
  assign dm_valid_o  = (state_q == DONE) && owner_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_wiscsc15_mem_arb.sv
// Bench for wiscsc15_mem_arb: a MEM_LAT=2 instance (u_dut) behind a registered
// memory model and a MEM_LAT=1 instance (u_lat1) behind a combinational one.
// Memory word at index a (addr[7:0]) resets to {a, 8'h5A}, except 0x40 = B123.
module tb_wiscsc15_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_grant, if_valid, dm_grant, dm_valid, mem_en, mem_we, busy;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        dm_req1;
  logic [15:0] dm_addr1;
  logic        if_grant1, if_valid1, dm_grant1, dm_valid1, mem_en1, mem_we1, busy1;
  logic [15:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  logic [15:0] mem [0:255];

  int nchk = 0;
  int nerr = 0;

  typedef struct packed { logic dm; logic [15:0] rd; } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        dm;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;   // expected rdata of that port at its valid pulse
  } vec_t;

  always #5 clk = ~clk;

  wiscsc15_mem_arb #(.AW(16), .DW(16), .MEM_LAT(2)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_grant_o(if_grant), .if_valid_o(if_valid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_grant_o(dm_grant), .dm_valid_o(dm_valid), .dm_rdata_o(dm_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  wiscsc15_mem_arb #(.AW(16), .DW(16), .MEM_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(1'b0), .if_addr_i(16'h0000),
    .if_grant_o(if_grant1), .if_valid_o(if_valid1), .if_rdata_o(if_rdata1),
    .dm_req_i(dm_req1), .dm_we_i(1'b0), .dm_addr_i(dm_addr1), .dm_wdata_i(16'h0000),
    .dm_grant_o(dm_grant1), .dm_valid_o(dm_valid1), .dm_rdata_o(dm_rdata1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1), .busy_o(busy1)
  );

  // Two-cycle memory: data appears the cycle after mem_en, garbage otherwise.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= {i[7:0], 8'h5A};
      mem[8'h40] <= 16'hB123;
      mem_rdata  <= 16'hDEAD;
    end else begin
      mem_rdata <= 16'hDEAD;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
      if (mem_en && mem_we)  mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  assign mem_rdata1 = mem[mem_addr1[7:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every valid pulse pops the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_grant || dm_grant) chk("one_grant", {31'd0, if_grant & dm_grant}, 32'd0);
      if (if_valid || dm_valid) begin
        chk("one_valid", {31'd0, if_valid & dm_valid}, 32'd0);
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL sb_unexpected_valid: got if_valid=%0b dm_valid=%0b expected none",
                   if_valid, dm_valid);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_port", {31'd0, dm_valid}, {31'd0, e.dm});
          chk("sb_rdata", {16'd0, dm_valid ? dm_rdata : if_rdata}, {16'd0, e.rd});
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int g, vv;
    sb.push_back({v.dm, v.exp_rd});
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    g = -1;
    for (int c = 1; c <= 12 && g < 0; c++) begin
      @(negedge clk);
      if (v.dm ? dm_grant : if_grant) begin
        g = c;
        chk("vec_mem_en", {31'd0, mem_en}, 32'd1);
        chk("vec_mem_addr", {16'd0, mem_addr}, {16'd0, v.addr});
        chk("vec_mem_we", {31'd0, mem_we}, {31'd0, v.we});
        if (v.we) chk("vec_mem_wdata", {16'd0, mem_wdata}, {16'd0, v.wdata});
        chk("vec_busy", {31'd0, busy}, 32'd1);
      end
    end
    chk("vec_grant_lat", g, 1);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    vv = -1;
    for (int c = 1; c <= 12 && vv < 0; c++) begin
      @(negedge clk);
      if (v.dm ? dm_valid : if_valid) vv = c;
    end
    chk("vec_valid_lat", vv, 2);
    repeat (2) @(negedge clk);   // turnaround cycle, then a clean IDLE
  endtask

  task automatic conflict_seq();
    int dg = -1, dv = -1, ig = -1, iv = -1;
    sb.push_back({1'b1, 16'h105A});
    sb.push_back({1'b0, 16'h205A});
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0010;
    if_req = 1'b1; if_addr = 16'h0020;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (dm_grant && dg < 0) begin dg = c; dm_req = 1'b0; end
      if (if_grant && ig < 0) begin ig = c; if_req = 1'b0; end
      if (dm_valid && dv < 0) dv = c;
      if (if_valid && iv < 0) iv = c;
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("cf_dm_grant", dg, 1);
    chk("cf_dm_valid", dv, 3);
    chk("cf_if_grant", ig, 6);
    chk("cf_if_valid", iv, 8);
  endtask

  task automatic fair_seq();
    logic [2:0] order, exp_order;
    int n = 0, g3 = -1;
`ifdef WISCSC15_ARB_FAIR_EN
    exp_order = 3'b011;   // bit k = 1 when grant k went to DM
    sb.push_back({1'b1, 16'h305A});
    sb.push_back({1'b1, 16'h305A});
    sb.push_back({1'b0, 16'h315A});
`else
    exp_order = 3'b111;
    sb.push_back({1'b1, 16'h305A});
    sb.push_back({1'b1, 16'h305A});
    sb.push_back({1'b1, 16'h305A});
`endif
    order = 3'b000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0030;
    if_req = 1'b1; if_addr = 16'h0031;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if ((dm_grant || if_grant) && n < 3) begin
        order[n] = dm_grant;
        n++;
        if (n == 3) begin g3 = c; dm_req = 1'b0; if_req = 1'b0; end
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    chk("fair_order", {29'd0, order}, {29'd0, exp_order});
    chk("fair_third_grant", g3, 11);
  endtask

  task automatic reset_mid_seq();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0060;     // cycle 0
    @(negedge clk);                                       // cycle 1
    chk("rm_grant", {31'd0, dm_grant}, 32'd1);
    dm_req = 1'b0;
    @(negedge clk);                                       // cycle 2
    rst = 1'b1;
    @(negedge clk);                                       // cycle 3
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_valids", {30'd0, if_valid, dm_valid}, 32'd0);
    chk("rm_rdata", {if_rdata, dm_rdata}, 32'd0);
    chk("rm_mem", {mem_addr, mem_wdata}, 32'd0);
    chk("rm_mem_en", {31'd0, mem_en}, 32'd0);
    rst = 1'b0;
    sb.push_back({1'b0, 16'h505A});
    if_req = 1'b1; if_addr = 16'h0050;
    @(negedge clk);                                       // cycle 4
    chk("rm_regrant", {31'd0, if_grant}, 32'd1);
    if_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic lat1_seq();
    int g = -1, v = -1;
    dm_req1 = 1'b1; dm_addr1 = 16'h0070;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dm_grant1 && g < 0) begin
        g = c;
        chk("l1_mem_en", {31'd0, mem_en1}, 32'd1);
        chk("l1_mem_addr", {16'd0, mem_addr1}, 32'h0070);
        dm_req1 = 1'b0;
      end
      if (dm_valid1 && v < 0) begin
        v = c;
        chk("l1_rdata", {16'd0, dm_rdata1}, 32'h705A);
      end
    end
    dm_req1 = 1'b0;
    chk("l1_grant_lat", g, 1);
    chk("l1_valid_lat", v, 2);
    chk("l1_if_quiet", {29'd0, if_grant1, if_valid1, mem_we1}, 32'd0);
    chk("l1_side", {if_rdata1, mem_wdata1}, 32'd0);
    chk("l1_busy", {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    vec_t tbl[7];
    tbl[0] = '{dm:1'b0, we:1'b0, addr:16'h0040, wdata:16'h0000, exp_rd:16'hB123};
    tbl[1] = '{dm:1'b1, we:1'b0, addr:16'h0012, wdata:16'h0000, exp_rd:16'h125A};
    tbl[2] = '{dm:1'b1, we:1'b1, addr:16'h0100, wdata:16'hBEEF, exp_rd:16'h125A};
    tbl[3] = '{dm:1'b1, we:1'b0, addr:16'h0100, wdata:16'h0000, exp_rd:16'hBEEF};
    tbl[4] = '{dm:1'b0, we:1'b0, addr:16'hFFFF, wdata:16'h0000, exp_rd:16'hFF5A};
    tbl[5] = '{dm:1'b1, we:1'b1, addr:16'h00AB, wdata:16'hFFFF, exp_rd:16'hBEEF};
    tbl[6] = '{dm:1'b1, we:1'b0, addr:16'h00AB, wdata:16'h0000, exp_rd:16'hFFFF};

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    dm_req1 = 1'b0; dm_addr1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {25'd0, if_grant, if_valid, dm_grant, dm_valid, mem_en, mem_we, busy}, 32'd0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 32'd0);
    chk("rst_mem", {mem_addr, mem_wdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);
    conflict_seq();
    fair_seq();
    reset_mid_seq();
    lat1_seq();

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
